// File: rtl/alu_md_seq.sv
// EX-stage ALU: single-cycle MIPS funct/branch ops plus a sequential multiply/divide unit with HI/LO.
// Optional macro ALU_FAST_MUL_EN selects a single-cycle combinational multiplier for mult/multu.
module alu_md_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       control,
   input  logic [WIDTH-1:0] read1,
   input  logic [WIDTH-1:0] foutput,
   input  logic [4:0]       shamt,
   input  logic             start,
   output logic [WIDTH-1:0] out,
   output logic             overflow,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic             divz
);
   localparam int unsigned W2   = 2 * WIDTH;
   localparam int unsigned SH_W = ($clog2(WIDTH) < 5) ? $clog2(WIDTH) : 5;

   localparam logic [5:0] OP_SLL  = 6'd0,  OP_BGEZ = 6'd1,  OP_SRL  = 6'd2,  OP_SRA   = 6'd3,
                          OP_BEQ  = 6'd4,  OP_BNE  = 6'd5,  OP_MFHI = 6'd16, OP_MTHI  = 6'd17,
                          OP_MFLO = 6'd18, OP_MTLO = 6'd19, OP_MULT = 6'd24, OP_MULTU = 6'd25,
                          OP_DIV  = 6'd26, OP_DIVU = 6'd27, OP_ADD  = 6'd32, OP_ADDU  = 6'd33,
                          OP_SUB  = 6'd34, OP_SUBU = 6'd35, OP_AND  = 6'd36, OP_OR    = 6'd37,
                          OP_XOR  = 6'd38, OP_NOR  = 6'd39, OP_SLT  = 6'd42, OP_SLTU  = 6'd43;

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] hi, lo, a_reg, b_reg, m_reg;
   logic [CNT_W-1:0] cnt;
   logic             is_div, neg_a, neg_b;
   logic             md_op_c, is_mul_c, signed_c, launch_c;
   logic [WIDTH-1:0] abs_a_c, abs_b_c, sum_add_c, sum_sub_c;
   logic [WIDTH:0]   mul_sum_c, div_sh_c, div_diff_c;
   logic [WIDTH-1:0] step_hi_c, step_lo_c, quot_c, rem_c;
   logic [W2-1:0]    prod_c;
   logic [SH_W-1:0]  sh_c;

   assign md_op_c  = (control == OP_MULT) || (control == OP_MULTU) ||
                     (control == OP_DIV)  || (control == OP_DIVU);
   assign is_mul_c = (control == OP_MULT) || (control == OP_MULTU);
   assign signed_c = (control == OP_MULT) || (control == OP_DIV);
   assign launch_c = start && md_op_c && (state == IDLE);
   assign abs_a_c  = (signed_c && read1[WIDTH-1])   ? -read1   : read1;
   assign abs_b_c  = (signed_c && foutput[WIDTH-1]) ? -foutput : foutput;

   assign sum_add_c = read1 + foutput;
   assign sum_sub_c = read1 - foutput;
   assign sh_c      = shamt[SH_W-1:0];

`ifdef ALU_FAST_MUL_EN
   logic [W2-1:0] fast_prod_c;
   assign fast_prod_c = W2'(abs_a_c) * W2'(abs_b_c);
`endif

   // One shift-add (multiply) or restoring shift-subtract (divide) step on the magnitudes
   always_comb begin
      mul_sum_c  = b_reg[0] ? ({1'b0, a_reg} + {1'b0, m_reg}) : {1'b0, a_reg};
      div_sh_c   = {a_reg, b_reg[WIDTH-1]};
      div_diff_c = div_sh_c - {1'b0, m_reg};
      if (is_div) begin
         step_hi_c = div_diff_c[WIDTH] ? div_sh_c[WIDTH-1:0] : div_diff_c[WIDTH-1:0];
         step_lo_c = {b_reg[WIDTH-2:0], ~div_diff_c[WIDTH]};
      end else begin
         step_hi_c = mul_sum_c[WIDTH:1];
         step_lo_c = {mul_sum_c[0], b_reg[WIDTH-1:1]};
      end
   end

   // Sign correction; negating the magnitude of the most-negative value returns itself
   assign prod_c = (neg_a ^ neg_b) ? -{a_reg, b_reg} : {a_reg, b_reg};
   assign quot_c = (neg_a ^ neg_b) ? -b_reg : b_reg;
   assign rem_c  = neg_a ? -a_reg : a_reg;

   always_comb begin
      out      = '0;
      overflow = 1'b0;
      zero     = 1'b0;
      case (control)
         OP_ADD: begin
            out      = sum_add_c;
            overflow = (read1[WIDTH-1] == foutput[WIDTH-1]) && (sum_add_c[WIDTH-1] != read1[WIDTH-1]);
         end
         OP_SUB: begin
            out      = sum_sub_c;
            overflow = (read1[WIDTH-1] != foutput[WIDTH-1]) && (sum_sub_c[WIDTH-1] != read1[WIDTH-1]);
         end
         OP_ADDU: out = sum_add_c;
         OP_SUBU: out = sum_sub_c;
         OP_AND:  out = read1 & foutput;
         OP_OR:   out = read1 | foutput;
         OP_XOR:  out = read1 ^ foutput;
         OP_NOR:  out = ~(read1 | foutput);
         OP_SLT:  out = WIDTH'($signed(read1) < $signed(foutput));
         OP_SLTU: out = WIDTH'(read1 < foutput);
         OP_SLL:  out = foutput << sh_c;
         OP_SRL:  out = foutput >> sh_c;
         OP_SRA:  out = WIDTH'($signed(foutput) >>> sh_c);
         OP_MFHI: out = hi;
         OP_MFLO: out = lo;
         OP_BEQ:  zero = (read1 == foutput);
         OP_BNE:  zero = (read1 != foutput);
         OP_BGEZ: zero = ~read1[WIDTH-1];
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (launch_c) begin
`ifdef ALU_FAST_MUL_EN
               state_nx = is_mul_c ? FIX : RUN;
`else
               state_nx = RUN;
`endif
            end
         end
         RUN:     if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
         FIX:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Operand latch, iteration datapath, HI/LO and handshake flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hi     <= '0;
         lo     <= '0;
         a_reg  <= '0;
         b_reg  <= '0;
         m_reg  <= '0;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_a  <= 1'b0;
         neg_b  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         divz   <= 1'b0;
      end else begin
         busy <= (state_nx != IDLE);
         done <= (state == FIX);
         case (state)
            IDLE: begin
               if (launch_c) begin
                  a_reg  <= '0;
                  b_reg  <= abs_a_c;
                  m_reg  <= abs_b_c;
                  cnt    <= '0;
                  is_div <= ~is_mul_c;
                  neg_a  <= signed_c & read1[WIDTH-1];
                  neg_b  <= signed_c & foutput[WIDTH-1];
                  divz   <= 1'b0;
`ifdef ALU_FAST_MUL_EN
                  if (is_mul_c) {a_reg, b_reg} <= fast_prod_c;
`endif
               end else if (start && (control == OP_MTHI)) begin
                  hi <= read1;
               end else if (start && (control == OP_MTLO)) begin
                  lo <= read1;
               end
            end
            RUN: begin
               a_reg <= step_hi_c;
               b_reg <= step_lo_c;
               cnt   <= (cnt == CNT_W'(WIDTH - 1)) ? '0 : cnt + CNT_W'(1);
            end
            FIX: begin
               if (is_div) begin
                  hi   <= rem_c;
                  lo   <= (m_reg == '0) ? '1 : quot_c;
                  divz <= (m_reg == '0);
               end else begin
                  {hi, lo} <= prod_c;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
